// File: rtl/pipeline_types.sv
// Shared types for the backend data-cache request path: arbiter FSM states,
// request ownership and the request holding-register layout.
package pipeline_types;

  localparam int DC_ADDR_W    = 32;
  localparam int DC_DATA_W    = 32;
  localparam int DC_STRB_W    = DC_DATA_W / 8;
  localparam int CACOP_CODE_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } dc_arb_state_t;

  typedef enum logic {
    OWNER_LSU   = 1'b0,
    OWNER_CACOP = 1'b1
  } dc_owner_t;

  // Field widths follow the package widths; the arbiter's ADDR_W/DATA_W
  // default to these and must stay equal to them.
  typedef struct packed {
    logic [DC_ADDR_W-1:0]    addr;
    logic                    we;
    logic [DC_STRB_W-1:0]    wstrb;
    logic [DC_DATA_W-1:0]    wdata;
    logic                    is_cacop;
    logic [CACOP_CODE_W-1:0] cacop_code;
  } dc_req_t;

endpackage

// File: rtl/dcache_req_arbiter_rr.sv
// Two-way round-robin grant: a lone requester wins; on a tie the requester
// that did not win last time wins. Purely combinational.
module rr_arbiter2
  import pipeline_types::*;
(
  input  logic      lsu_valid_i,
  input  logic      cacop_valid_i,
  input  dc_owner_t last_grant_i,
  output logic      gnt_lsu_o,
  output logic      gnt_cacop_o
);

  // Exactly one grant when at least one requester is valid.
  always_comb begin
    gnt_lsu_o   = lsu_valid_i   && (!cacop_valid_i || (last_grant_i == OWNER_CACOP));
    gnt_cacop_o = cacop_valid_i && (!lsu_valid_i   || (last_grant_i == OWNER_LSU));
  end

endmodule

// File: rtl/dcache_req_arbiter.sv
// Single-outstanding arbiter between the LSU and CACOP paths and the dcache
// request port. A granted request is held stable until the cache accepts it,
// the one response is routed to its owner, and responses of requests that
// were in flight during a flush are swallowed.
//
// Handshakes: every *_valid/*_ready pair transfers when both are high in the
// same cycle. A source holds valid and its fields stable until it sees ready;
// a request withdrawn before ready is never issued. Response signals are
// one-cycle pulses with no backpressure.
module dcache_req_arbiter
  import pipeline_types::*;
#(
  parameter int ADDR_W = DC_ADDR_W,
  parameter int DATA_W = DC_DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_W-1:0]       lsu_addr,
  input  logic                    lsu_we,
  input  logic [DATA_W/8-1:0]     lsu_wstrb,
  input  logic [DATA_W-1:0]       lsu_wdata,
  output logic                    lsu_resp_valid,
  output logic [DATA_W-1:0]       lsu_rdata,
  input  logic                    cacop_req_valid,
  output logic                    cacop_req_ready,
  input  logic [ADDR_W-1:0]       cacop_addr,
  input  logic [4:0]              cacop_code,
  output logic                    cacop_done,
  output logic                    dc_req_valid,
  input  logic                    dc_req_ready,
  output logic [ADDR_W-1:0]       dc_addr,
  output logic                    dc_we,
  output logic [DATA_W/8-1:0]     dc_wstrb,
  output logic [DATA_W-1:0]       dc_wdata,
  output logic                    dc_is_cacop,
  output logic [4:0]              dc_cacop_code,
  input  logic                    dc_resp_valid,
  input  logic [DATA_W-1:0]       dc_rdata,
  output logic [1:0]              dbg_state
);

  dc_arb_state_t state_q, state_d;
  dc_req_t       hold_q, hold_d;
  dc_owner_t     sel_q, sel_d;
  dc_owner_t     last_grant_q, last_grant_d;
  logic          drop_q, drop_d;

  logic gnt_lsu, gnt_cacop;
  logic grant_en;
  logic resp_fire;
  logic deliver;

  rr_arbiter2 u_rr (
    .lsu_valid_i   (lsu_req_valid),
    .cacop_valid_i (cacop_req_valid),
    .last_grant_i  (last_grant_q),
    .gnt_lsu_o     (gnt_lsu),
    .gnt_cacop_o   (gnt_cacop)
  );

  // Grants only happen in IDLE, never during a flush or reset.
  assign grant_en = (state_q == IDLE) && !flush && !rst;

  // A response counts in WAIT, or in REQ when it lands with the accept.
  assign resp_fire = dc_resp_valid &&
                     ((state_q == WAIT) || ((state_q == REQ) && dc_req_ready));
  assign deliver   = resp_fire && !drop_q && !flush && !rst;

  // Next-state, holding-register capture and flush tracking.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    drop_d       = drop_q;
    case (state_q)
      IDLE: begin
        if (grant_en && gnt_lsu) begin
          hold_d       = '{addr: lsu_addr, we: lsu_we, wstrb: lsu_wstrb,
                           wdata: lsu_wdata, is_cacop: 1'b0, cacop_code: '0};
          sel_d        = OWNER_LSU;
          last_grant_d = OWNER_LSU;
          drop_d       = 1'b0;
          state_d      = REQ;
        end else if (grant_en && gnt_cacop) begin
          hold_d       = '{addr: cacop_addr, we: 1'b0, wstrb: '0,
                           wdata: '0, is_cacop: 1'b1, cacop_code: cacop_code};
          sel_d        = OWNER_CACOP;
          last_grant_d = OWNER_CACOP;
          drop_d       = 1'b0;
          state_d      = REQ;
        end
      end
      REQ: begin
        if (flush) drop_d = 1'b1;
        if (dc_req_ready) state_d = dc_resp_valid ? IDLE : WAIT;
      end
      WAIT: begin
        if (flush) drop_d = 1'b1;
        if (dc_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and holding registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      sel_q        <= OWNER_LSU;
      last_grant_q <= OWNER_CACOP;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      drop_q       <= drop_d;
    end
  end

  // Requester handshakes and combinational response routing.
  assign lsu_req_ready   = grant_en && gnt_lsu;
  assign cacop_req_ready = grant_en && gnt_cacop && !gnt_lsu;
  assign lsu_resp_valid  = deliver && (sel_q == OWNER_LSU);
  assign lsu_rdata       = lsu_resp_valid ? dc_rdata : '0;
  assign cacop_done      = deliver && (sel_q == OWNER_CACOP);

  // The dcache side is driven straight from the holding register.
  assign dc_req_valid  = (state_q == REQ) && !rst;
  assign dc_addr       = rst ? '0 : hold_q.addr;
  assign dc_we         = rst ? 1'b0 : hold_q.we;
  assign dc_wstrb      = rst ? '0 : hold_q.wstrb;
  assign dc_wdata      = rst ? '0 : hold_q.wdata;
  assign dc_is_cacop   = rst ? 1'b0 : hold_q.is_cacop;
  assign dc_cacop_code = rst ? '0 : hold_q.cacop_code;

  assign dbg_state = state_q;

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Bench for dcache_req_arbiter: scenario tasks with inline checks plus a
// response scoreboard fed when stimulus is driven.
module tb_dcache_req_arbiter;
  import pipeline_types::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          lsu_req_valid;
  logic          lsu_req_ready;
  logic [AW-1:0] lsu_addr;
  logic          lsu_we;
  logic [SW-1:0] lsu_wstrb;
  logic [DW-1:0] lsu_wdata;
  logic          lsu_resp_valid;
  logic [DW-1:0] lsu_rdata;
  logic          cacop_req_valid;
  logic          cacop_req_ready;
  logic [AW-1:0] cacop_addr;
  logic [4:0]    cacop_code;
  logic          cacop_done;
  logic          dc_req_valid;
  logic          dc_req_ready;
  logic [AW-1:0] dc_addr;
  logic          dc_we;
  logic [SW-1:0] dc_wstrb;
  logic [DW-1:0] dc_wdata;
  logic          dc_is_cacop;
  logic [4:0]    dc_cacop_code;
  logic          dc_resp_valid;
  logic [DW-1:0] dc_rdata;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  // Expected responses: {is_cacop, lsu_rdata}; CACOP entries carry zero data.
  logic [DW:0] exp_q[$];
  logic [DW:0] mon_got;
  logic [DW:0] mon_exp;

  dcache_req_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_addr(lsu_addr), .lsu_we(lsu_we), .lsu_wstrb(lsu_wstrb),
    .lsu_wdata(lsu_wdata), .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .cacop_req_valid(cacop_req_valid), .cacop_req_ready(cacop_req_ready),
    .cacop_addr(cacop_addr), .cacop_code(cacop_code), .cacop_done(cacop_done),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_addr(dc_addr),
    .dc_we(dc_we), .dc_wstrb(dc_wstrb), .dc_wdata(dc_wdata),
    .dc_is_cacop(dc_is_cacop), .dc_cacop_code(dc_cacop_code),
    .dc_resp_valid(dc_resp_valid), .dc_rdata(dc_rdata), .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every response pulse must match the head of exp_q.
  always @(negedge clk) begin
    if (lsu_resp_valid || cacop_done) begin
      mon_got = {cacop_done, lsu_rdata};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL resp_unexpected got=%h required=none", mon_got);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_got !== mon_exp) begin
          bad++;
          $display("FAIL resp_data got=%h required=%h", mon_got, mon_exp);
        end
      end
    end
    if (!lsu_resp_valid) begin
      total++;
      if (lsu_rdata !== '0) begin
        bad++;
        $display("FAIL rdata_idle got=%h required=0", lsu_rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; lsu_req_valid = 0; lsu_addr = '0; lsu_we = 0; lsu_wstrb = '0;
    lsu_wdata = '0; cacop_req_valid = 0; cacop_addr = '0; cacop_code = '0;
    dc_req_ready = 0; dc_resp_valid = 0; dc_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    lsu_req_valid = 1; cacop_req_valid = 1; dc_resp_valid = 1; dc_rdata = 32'h1234_5678;
    step();
    step();
    @(negedge clk);
    total++; if (lsu_req_ready !== 1'b0) begin bad++; $display("FAIL rst_lsu_ready got=%b required=0", lsu_req_ready); end
    total++; if (cacop_req_ready !== 1'b0) begin bad++; $display("FAIL rst_cacop_ready got=%b required=0", cacop_req_ready); end
    total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL rst_dc_valid got=%b required=0", dc_req_valid); end
    total++; if (lsu_resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp got=%b required=0", lsu_resp_valid); end
    step();
    rst = 0;
    idle_inputs();
    @(negedge clk);
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rst_state got=%0d required=%0d", dbg_state, IDLE); end
    total++; if ({dc_addr, dc_we, dc_wstrb, dc_wdata, dc_is_cacop, dc_cacop_code} !== '0) begin
      bad++; $display("FAIL rst_dc_fields got=%h/%h/%h required=0", dc_addr, dc_wdata, dc_wstrb);
    end
    total++; if (cacop_done !== 1'b0) begin bad++; $display("FAIL rst_cacop_done got=%b required=0", cacop_done); end
  endtask

  task automatic test_tie();
    logic [AW-1:0] la, ca, g_addr;
    logic [4:0]    cc;
    logic [DW-1:0] rd;
    logic          want_cacop;
    la = $urandom; ca = $urandom; cc = 5'($urandom_range(0, 31));
    step();
    lsu_req_valid = 1; lsu_addr = la; lsu_we = 0;
    cacop_req_valid = 1; cacop_addr = ca; cacop_code = cc;
    for (int i = 0; i < 6; i++) begin
      want_cacop = (i % 2) == 1;
      @(negedge clk);
      total++; if (lsu_req_ready !== !want_cacop) begin bad++; $display("FAIL tie_lsu_ready r%0d got=%b required=%b", i, lsu_req_ready, !want_cacop); end
      total++; if (cacop_req_ready !== want_cacop) begin bad++; $display("FAIL tie_cacop_ready r%0d got=%b required=%b", i, cacop_req_ready, want_cacop); end
      g_addr = want_cacop ? ca : la;
      step();
      rd = $urandom;
      dc_req_ready = 1; dc_resp_valid = 1; dc_rdata = rd;
      exp_q.push_back({want_cacop, want_cacop ? 32'h0 : rd});
      if (want_cacop) begin ca = $urandom; cacop_addr = ca; end
      else begin la = $urandom; lsu_addr = la; end
      @(negedge clk);
      total++; if (dc_req_valid !== 1'b1) begin bad++; $display("FAIL tie_dc_valid r%0d got=%b required=1", i, dc_req_valid); end
      total++; if (dc_is_cacop !== want_cacop) begin bad++; $display("FAIL tie_owner r%0d got=%b required=%b", i, dc_is_cacop, want_cacop); end
      total++; if (dc_addr !== g_addr) begin bad++; $display("FAIL tie_addr r%0d got=%h required=%h", i, dc_addr, g_addr); end
      if (want_cacop) begin
        total++; if (dc_cacop_code !== cc) begin bad++; $display("FAIL tie_code r%0d got=%h required=%h", i, dc_cacop_code, cc); end
      end
      total++; if ((lsu_req_ready | cacop_req_ready) !== 1'b0) begin bad++; $display("FAIL tie_ready_in_req r%0d got=1 required=0", i); end
      step();
      dc_req_ready = 0; dc_resp_valid = 0; dc_rdata = '0;
      if (i == 5) begin lsu_req_valid = 0; cacop_req_valid = 0; end
    end
  endtask

  task automatic test_single_load();
    step();
    lsu_req_valid = 1; lsu_addr = 32'h1C00_0040; lsu_we = 0;
    @(negedge clk);
    total++; if (lsu_req_ready !== 1'b1) begin bad++; $display("FAIL load_ready got=%b required=1", lsu_req_ready); end
    total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL load_valid_early got=%b required=0", dc_req_valid); end
    step();
    lsu_req_valid = 0; lsu_addr = $urandom; dc_req_ready = 1;
    @(negedge clk);
    total++; if (dc_req_valid !== 1'b1) begin bad++; $display("FAIL load_valid got=%b required=1", dc_req_valid); end
    total++; if (dc_addr !== 32'h1C00_0040) begin bad++; $display("FAIL load_addr got=%h required=1c000040", dc_addr); end
    total++; if ({dc_we, dc_is_cacop} !== 2'b00) begin bad++; $display("FAIL load_kind got=%b required=00", {dc_we, dc_is_cacop}); end
    step();
    dc_req_ready = 0;
    @(negedge clk);
    total++; if (dbg_state !== WAIT) begin bad++; $display("FAIL load_wait got=%0d required=%0d", dbg_state, WAIT); end
    step();
    dc_resp_valid = 1; dc_rdata = 32'hDEAD_BEEF;
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    @(negedge clk);
    total++; if (lsu_resp_valid !== 1'b1) begin bad++; $display("FAIL load_resp got=%b required=1", lsu_resp_valid); end
    step();
    dc_resp_valid = 0; dc_rdata = '0;
    @(negedge clk);
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL load_idle got=%0d required=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] la;
    logic [DW-1:0] wd, rd;
    la = $urandom & 32'hFFFF_FFFC; wd = $urandom; rd = $urandom;
    step();
    lsu_req_valid = 1; lsu_addr = la; lsu_we = 1; lsu_wstrb = 4'hF; lsu_wdata = wd;
    @(negedge clk);
    total++; if (lsu_req_ready !== 1'b1) begin bad++; $display("FAIL bp_grant got=%b required=1", lsu_req_ready); end
    for (int c = 0; c < 6; c++) begin
      step();
      if (c == 0) begin
        lsu_req_valid = 0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_wstrb = '0; lsu_we = 0;
        cacop_req_valid = 1; cacop_addr = $urandom; cacop_code = 5'd3;
      end
      dc_req_ready = (c == 5);
      @(negedge clk);
      total++; if (dc_req_valid !== 1'b1) begin bad++; $display("FAIL bp_valid c%0d got=%b required=1", c, dc_req_valid); end
      total++; if ({dc_addr, dc_wdata, dc_wstrb, dc_we} !== {la, wd, 4'hF, 1'b1}) begin
        bad++; $display("FAIL bp_hold c%0d got=%h/%h/%h required=%h/%h/f", c, dc_addr, dc_wdata, dc_wstrb, la, wd);
      end
      total++; if (cacop_req_ready !== 1'b0) begin bad++; $display("FAIL bp_no_grant c%0d got=%b required=0", c, cacop_req_ready); end
    end
    step();
    dc_req_ready = 0; cacop_req_valid = 0;
    @(negedge clk);
    total++; if (dbg_state !== WAIT) begin bad++; $display("FAIL bp_wait got=%0d required=%0d", dbg_state, WAIT); end
    step();
    dc_resp_valid = 1; dc_rdata = rd;
    exp_q.push_back({1'b0, rd});
    @(negedge clk);
    total++; if (lsu_resp_valid !== 1'b1) begin bad++; $display("FAIL bp_resp got=%b required=1", lsu_resp_valid); end
    step();
    dc_resp_valid = 0; dc_rdata = '0;
    step();
    @(negedge clk);
    total++; if (dc_req_valid !== 1'b0) begin bad++; $display("FAIL bp_withdrawn got=%b required=0", dc_req_valid); end
  endtask

  task automatic test_flush_wait();
    logic [AW-1:0] na;
    logic [DW-1:0] rd;
    na = $urandom; rd = $urandom;
    step();
    lsu_req_valid = 1; lsu_addr = $urandom; lsu_we = 1; lsu_wstrb = 4'h3; lsu_wdata = $urandom; flush = 1;
    @(negedge clk);
    total++; if (lsu_req_ready !== 1'b0) begin bad++; $display("FAIL fw_idle_flush got=%b required=0", lsu_req_ready); end
    step();
    flush = 0;
    @(negedge clk);
    total++; if (lsu_req_ready !== 1'b1) begin bad++; $display("FAIL fw_grant got=%b required=1", lsu_req_ready); end
    step();
    lsu_req_valid = 0; dc_req_ready = 1;
    step();
    dc_req_ready = 0; flush = 1;
    @(negedge clk);
    total++; if (dbg_state !== WAIT) begin bad++; $display("FAIL fw_wait got=%0d required=%0d", dbg_state, WAIT); end
    step();
    flush = 0;
    step();
    dc_resp_valid = 1; dc_rdata = $urandom;
    @(negedge clk);
    total++; if (lsu_resp_valid !== 1'b0) begin bad++; $display("FAIL fw_swallow got=%b required=0", lsu_resp_valid); end
    step();
    dc_resp_valid = 0; dc_rdata = '0;
    lsu_req_valid = 1; lsu_addr = na; lsu_we = 0; lsu_wstrb = '0; lsu_wdata = '0;
    @(negedge clk);
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL fw_idle got=%0d required=%0d", dbg_state, IDLE); end
    total++; if (lsu_req_ready !== 1'b1) begin bad++; $display("FAIL fw_regrant got=%b required=1", lsu_req_ready); end
    step();
    lsu_req_valid = 0; dc_req_ready = 1; dc_resp_valid = 1; dc_rdata = rd;
    exp_q.push_back({1'b0, rd});
    @(negedge clk);
    total++; if (dc_addr !== na) begin bad++; $display("FAIL fw_next_addr got=%h required=%h", dc_addr, na); end
    total++; if (lsu_resp_valid !== 1'b1) begin bad++; $display("FAIL fw_next_resp got=%b required=1", lsu_resp_valid); end
    step();
    dc_req_ready = 0; dc_resp_valid = 0; dc_rdata = '0;
  endtask

  task automatic test_flush_req();
    step();
    lsu_req_valid = 1; lsu_addr = $urandom; lsu_we = 0;
    @(negedge clk);
    total++; if (lsu_req_ready !== 1'b1) begin bad++; $display("FAIL fr_grant got=%b required=1", lsu_req_ready); end
    step();
    lsu_req_valid = 0; flush = 1;
    @(negedge clk);
    total++; if (dc_req_valid !== 1'b1) begin bad++; $display("FAIL fr_hold_flush got=%b required=1", dc_req_valid); end
    step();
    flush = 0;
    @(negedge clk);
    total++; if (dc_req_valid !== 1'b1) begin bad++; $display("FAIL fr_hold_after got=%b required=1", dc_req_valid); end
    step();
    dc_req_ready = 1;
    step();
    dc_req_ready = 0; dc_resp_valid = 1; dc_rdata = $urandom;
    @(negedge clk);
    total++; if (lsu_resp_valid !== 1'b0) begin bad++; $display("FAIL fr_swallow got=%b required=0", lsu_resp_valid); end
    step();
    dc_resp_valid = 0; dc_rdata = '0;
    cacop_req_valid = 1; cacop_addr = $urandom; cacop_code = 5'd9;
    @(negedge clk);
    total++; if (cacop_req_ready !== 1'b1) begin bad++; $display("FAIL fr_cacop_grant got=%b required=1", cacop_req_ready); end
    step();
    cacop_req_valid = 0; dc_req_ready = 1;
    step();
    dc_req_ready = 0; dc_resp_valid = 1; flush = 1;
    @(negedge clk);
    total++; if (cacop_done !== 1'b0) begin bad++; $display("FAIL fr_flush_same_cycle got=%b required=0", cacop_done); end
    step();
    dc_resp_valid = 0; flush = 0;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rd;
    rd = $urandom;
    step();
    cacop_req_valid = 1; cacop_addr = $urandom; cacop_code = 5'd17;
    @(negedge clk);
    total++; if (cacop_req_ready !== 1'b1) begin bad++; $display("FAIL rm_grant got=%b required=1", cacop_req_ready); end
    step();
    cacop_req_valid = 0; dc_req_ready = 1;
    @(negedge clk);
    total++; if ({dc_is_cacop, dc_cacop_code} !== {1'b1, 5'd17}) begin bad++; $display("FAIL rm_fields got=%b/%0d required=1/17", dc_is_cacop, dc_cacop_code); end
    step();
    dc_req_ready = 0;
    step();
    rst = 1;
    step();
    rst = 0; dc_resp_valid = 1; dc_rdata = $urandom;
    @(negedge clk);
    total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL rm_state got=%0d required=%0d", dbg_state, IDLE); end
    total++; if ({dc_req_valid, dc_addr, dc_is_cacop, dc_cacop_code} !== '0) begin bad++; $display("FAIL rm_outputs got=%b/%h/%b/%0d required=0", dc_req_valid, dc_addr, dc_is_cacop, dc_cacop_code); end
    total++; if ({cacop_done, lsu_resp_valid} !== 2'b00) begin bad++; $display("FAIL rm_stale_resp got=%b required=00", {cacop_done, lsu_resp_valid}); end
    step();
    dc_resp_valid = 0; dc_rdata = '0;
    lsu_req_valid = 1; lsu_addr = $urandom; cacop_req_valid = 1;
    @(negedge clk);
    total++; if ({lsu_req_ready, cacop_req_ready} !== 2'b10) begin bad++; $display("FAIL rm_tie got=%b required=10", {lsu_req_ready, cacop_req_ready}); end
    step();
    lsu_req_valid = 0; cacop_req_valid = 0; dc_req_ready = 1; dc_resp_valid = 1; dc_rdata = rd;
    exp_q.push_back({1'b0, rd});
    @(negedge clk);
    total++; if (lsu_resp_valid !== 1'b1) begin bad++; $display("FAIL rm_after_resp got=%b required=1", lsu_resp_valid); end
    step();
    dc_req_ready = 0; dc_resp_valid = 0; dc_rdata = '0;
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single_load();
    test_backpressure();
    test_flush_wait();
    test_flush_req();
    test_reset_mid();
    step();
    step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
